// File: rtl/gl_pkg.sv
// Shared rasterizer back-end types: fragment word layout, colour format, defaults.
package gl_pkg;

  localparam int unsigned RES_W_DEF = 640;
  localparam int unsigned RES_H_DEF = 480;

  localparam int unsigned FRAG_W = 96;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned C_W    = 6;

  localparam int unsigned Y_LSB = 80;
  localparam int unsigned X_LSB = 64;
  localparam int unsigned R_LSB = 50;
  localparam int unsigned G_LSB = 42;
  localparam int unsigned B_LSB = 34;

  typedef struct packed {
    logic [C_W-1:0] r;
    logic [C_W-1:0] g;
    logic [C_W-1:0] b;
  } rgb666_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    rgb666_t        rgb;
  } fragment_t;

  // Extract coordinate and colour fields from a raw FIFO word.
  function automatic fragment_t unpack_fragment(input logic [FRAG_W-1:0] w);
    fragment_t f;
    logic      unused_w;
    unused_w = ^w;  // remaining fields of the word carry nothing for this consumer
    f.x      = w[X_LSB +: X_W];
    f.y      = w[Y_LSB +: Y_W];
    f.rgb.r  = w[R_LSB +: C_W];
    f.rgb.g  = w[G_LSB +: C_W];
    f.rgb.b  = w[B_LSB +: C_W];
    return f;
  endfunction

endpackage

// File: rtl/gl_fb_addr.sv
// Linear framebuffer address y*RES_W+x with an in-bounds flag (also used by scan-out).
module gl_fb_addr
  import gl_pkg::*;
#(
  parameter int unsigned RES_W     = RES_W_DEF,
  parameter int unsigned RES_H     = RES_H_DEF,
  parameter int unsigned X_BITS    = 10,
  parameter int unsigned Y_BITS    = 9,
  parameter int unsigned ADDR_BITS = 19
) (
  input  logic [X_BITS-1:0]    x,
  input  logic [Y_BITS-1:0]    y,
  output logic [ADDR_BITS-1:0] addr_c,
  output logic                 in_range_c
);

  // Unsigned address arithmetic; legal coordinates never exceed the address width.
  always_comb begin
    addr_c     = ADDR_BITS'(y) * ADDR_BITS'(RES_W) + ADDR_BITS'(x);
    in_range_c = (32'(x) < RES_W) && (32'(y) < RES_H);
  end

endmodule

// File: rtl/gl_fragment_writer.sv
// Fragment FIFO consumer: pops, bounds-checks and writes pixels; full-screen clear.
module gl_fragment_writer
  import gl_pkg::*;
#(
  parameter int unsigned RES_W      = RES_W_DEF,
  parameter int unsigned RES_H      = RES_H_DEF,
  parameter int unsigned X_BITS     = 10,
  parameter int unsigned Y_BITS     = 9,
  parameter int unsigned ADDR_BITS  = 19,
  parameter int unsigned COLOR_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    empty,
  output logic                    rd_en,
  input  logic [FRAG_W-1:0]       rd_data,
  output logic                    fifo_ready,
  input  logic                    clear_req,
  input  logic [3*COLOR_BITS-1:0] clear_color,
  output logic                    clear_done,
  output logic                    fb_we,
  output logic [ADDR_BITS-1:0]    fb_addr,
  output logic [3*COLOR_BITS-1:0] fb_data,
  input  logic                    fb_busy,
  output logic [31:0]             pixel_count,
  output logic [15:0]             drop_count
);

  localparam int unsigned RGB_W    = 3 * COLOR_BITS;
  localparam int unsigned PIXC_W   = 32;
  localparam int unsigned DROPC_W  = 16;
  localparam int unsigned N_PIX    = RES_W * RES_H;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_WRITE,
    S_CLEAR
  } state_e;

  state_e               state_q, state_d;
  logic                 rd_en_q, rd_en_d;
  logic                 fifo_ready_q, fifo_ready_d;
  logic                 clear_done_q, clear_done_d;
  logic                 fb_we_q, fb_we_d;
  logic [ADDR_BITS-1:0] fb_addr_q, fb_addr_d;
  logic [RGB_W-1:0]     fb_data_q, fb_data_d;
  logic [PIXC_W-1:0]    pixel_count_q, pixel_count_d;
  logic [DROPC_W-1:0]   drop_count_q, drop_count_d;

  fragment_t            frag_c;
  logic [ADDR_BITS-1:0] frag_addr_c;
  logic                 frag_ok_c;
  logic                 pop_ok_c;

  // Field extraction of the word presented by the FIFO.
  always_comb frag_c = unpack_fragment(rd_data);

  gl_fb_addr #(
    .RES_W    (RES_W),
    .RES_H    (RES_H),
    .X_BITS   (X_BITS),
    .Y_BITS   (Y_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_fb_addr (
    .x         (X_BITS'(frag_c.x)),
    .y         (Y_BITS'(frag_c.y)),
    .addr_c    (frag_addr_c),
    .in_range_c(frag_ok_c)
  );

  // Next-state and registered-output logic; pops ahead on the way back to IDLE to keep 3 cycles/fragment.
  always_comb begin
    state_d       = state_q;
    rd_en_d       = 1'b0;
    clear_done_d  = 1'b0;
    fb_we_d       = fb_we_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    pixel_count_d = pixel_count_q;
    drop_count_d  = drop_count_q;
    pop_ok_c      = !empty && !clear_req;

    case (state_q)
      S_IDLE: begin
        if (rd_en_q) begin
          state_d = S_LATCH;
        end else if (clear_req) begin
          state_d   = S_CLEAR;
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
          fb_data_d = clear_color;
        end else if (!empty) begin
          rd_en_d = 1'b1;
        end
      end
      S_LATCH: begin
        if (frag_ok_c) begin
          state_d   = S_WRITE;
          fb_we_d   = 1'b1;
          fb_addr_d = frag_addr_c;
          fb_data_d = RGB_W'(frag_c.rgb);
        end else begin
          state_d = S_IDLE;
          rd_en_d = pop_ok_c;
          if (drop_count_q != '1) drop_count_d = drop_count_q + DROPC_W'(1);
        end
      end
      S_WRITE: begin
        if (!fb_busy) begin
          state_d       = S_IDLE;
          fb_we_d       = 1'b0;
          pixel_count_d = pixel_count_q + PIXC_W'(1);
          rd_en_d       = pop_ok_c;
        end
      end
      S_CLEAR: begin
        if (!fb_busy) begin
          if (fb_addr_q == LAST_ADDR) begin
            state_d      = S_IDLE;
            fb_we_d      = 1'b0;
            clear_done_d = 1'b1;
          end else begin
            fb_addr_d = fb_addr_q + ADDR_BITS'(1);
            fb_data_d = clear_color;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    fifo_ready_d = (state_d != S_CLEAR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rd_en_q       <= 1'b0;
      fifo_ready_q  <= 1'b0;
      clear_done_q  <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      pixel_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      rd_en_q       <= rd_en_d;
      fifo_ready_q  <= fifo_ready_d;
      clear_done_q  <= clear_done_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      pixel_count_q <= pixel_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign fifo_ready  = fifo_ready_q;
  assign clear_done  = clear_done_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign pixel_count = pixel_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_gl_fragment_writer.sv
// Bench for gl_fragment_writer: FIFO model, write scoreboard, per-feature scenario tasks.
module tb_gl_fragment_writer;

  localparam int unsigned RES_W = 640;
  localparam int unsigned RES_H = 32;
  localparam int unsigned N_PIX = RES_W * RES_H;

  typedef struct packed {
    logic [18:0] addr;
    logic [17:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        empty;
  logic        rd_en;
  logic [95:0] rd_data;
  logic        fifo_ready;
  logic        clear_req;
  logic [17:0] clear_color;
  logic        clear_done;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [17:0] fb_data;
  logic        fb_busy;
  logic [31:0] pixel_count;
  logic [15:0] drop_count;

  logic [95:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_pixels = 0;
  int          exp_drops = 0;

  gl_fragment_writer #(
    .RES_W(RES_W),
    .RES_H(RES_H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .empty      (empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_ready (fifo_ready),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .clear_done (clear_done),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_busy    (fb_busy),
    .pixel_count(pixel_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // FIFO model: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en && (rd_ptr != wr_ptr)) begin
      rd_data <= fifo_mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end
  assign empty = (rd_ptr == wr_ptr);

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic push_frag(input int x, input int y, input int r, input int g, input int b);
    logic [95:0] w;
    exp_t        e;
    w        = {$urandom, $urandom, $urandom};
    w[88:80] = 9'(y);
    w[73:64] = 10'(x);
    w[55:50] = 6'(r);
    w[47:42] = 6'(g);
    w[39:34] = 6'(b);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
    if (x < RES_W && y < RES_H) begin
      e.addr = 19'(y * 640 + x);
      e.data = {6'(r), 6'(g), 6'(b)};
      exp_q.push_back(e);
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
  endtask

  task automatic wait_rd_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    rst_n = 1'b0;
    push_frag(5, 2, 63, 0, 31);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en, fb_we, clear_done, fifo_ready} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {rd_en, fb_we, clear_done, fifo_ready});
    end
    n_checks++;
    if (fb_addr !== 19'd0 || fb_data !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_bus: got addr %h data %h expected 0 0", fb_addr, fb_data);
    end
    n_checks++;
    if (pixel_count !== 32'd0 || drop_count !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_counts: got %0d %0d expected 0 0", pixel_count, drop_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_ready !== 1'b1 || rd_en !== 1'b1) begin
      n_errors++;
      $display("FAIL first_edge: got fifo_ready %b rd_en %b expected 1 1", fifo_ready, rd_en);
    end
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL latch_cycle: got fb_we %b rd_en %b expected 0 0", fb_we, rd_en);
    end
    @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL first_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || pixel_count !== 32'(exp_pixels)) begin
      n_errors++;
      $display("FAIL first_count: got we %b count %0d expected 0 %0d", fb_we, pixel_count, exp_pixels);
    end
    ok = 1'b1;
  endtask

  task automatic test_drop();
    exp_t e;
    bit   ok;
    push_frag(640, 10, 1, 2, 3);
    push_frag(639, RES_H - 1, 10, 20, 30);
    push_frag(3, RES_H, 1, 1, 1);
    push_frag(0, 0, 7, 7, 7);
    wait_rd_en(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL drop_rd_en_timeout: got no rd_en expected rd_en");
    end
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || drop_count !== 16'(exp_drops)) begin
      n_errors++;
      $display("FAIL drop_latch: got we %b drops %0d expected 0 %0d", fb_we, drop_count, exp_drops);
    end
    exp_drops++;
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || rd_en !== 1'b1 || drop_count !== 16'(exp_drops)) begin
      n_errors++;
      $display("FAIL drop_return: got we %b rd_en %b drops %0d expected 0 1 %0d",
               fb_we, rd_en, drop_count, exp_drops);
    end
    repeat (2) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL corner_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1 || pixel_count !== 32'(exp_pixels)) begin
      n_errors++;
      $display("FAIL b2b_pop: got rd_en %b count %0d expected 1 %0d", rd_en, pixel_count, exp_pixels);
    end
    exp_drops++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1 || fb_we !== 1'b0 || drop_count !== 16'(exp_drops)) begin
      n_errors++;
      $display("FAIL y_edge_drop: got rd_en %b we %b drops %0d expected 1 0 %0d",
               rd_en, fb_we, drop_count, exp_drops);
    end
    repeat (2) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL origin_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || pixel_count !== 32'(exp_pixels) || drop_count !== 16'(exp_drops)) begin
      n_errors++;
      $display("FAIL drop_totals: got we %b count %0d drops %0d expected 0 %0d %0d",
               fb_we, pixel_count, drop_count, exp_pixels, exp_drops);
    end
  endtask

  task automatic test_busy();
    exp_t e;
    bit   ok;
    fb_busy = 1'b1;
    push_frag(100, 20, 21, 42, 5);
    wait_rd_en(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL busy_rd_en_timeout: got no rd_en expected rd_en");
    end
    repeat (2) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL busy_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data || pixel_count !== 32'(exp_pixels)) begin
        n_errors++;
        $display("FAIL busy_hold%0d: got we %b addr %0d data %h count %0d expected 1 %0d %h %0d",
                 k, fb_we, fb_addr, fb_data, pixel_count, e.addr, e.data, exp_pixels);
      end
    end
    fb_busy = 1'b0;
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || pixel_count !== 32'(exp_pixels)) begin
      n_errors++;
      $display("FAIL busy_accept: got we %b count %0d expected 0 %0d", fb_we, pixel_count, exp_pixels);
    end
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || pixel_count !== 32'(exp_pixels)) begin
      n_errors++;
      $display("FAIL busy_single: got we %b count %0d expected 0 %0d", fb_we, pixel_count, exp_pixels);
    end
  endtask

  task automatic test_clear();
    int  exp_addr = 0;
    int  bad = 0;
    int  side = 0;
    int  first_bad_addr = -1;
    int  first_bad_exp = -1;
    bit  done = 1'b0;
    bit  busy;
    clear_color = 18'h15555;
    clear_req   = 1'b1;
    for (int cyc = 0; cyc < 2 * N_PIX + 64; cyc++) begin
      @(negedge clk);
      if (fb_we !== 1'b1 || fb_addr !== 19'(exp_addr) || fb_data !== 18'h15555) begin
        if (bad == 0) begin
          first_bad_addr = int'(fb_addr);
          first_bad_exp  = exp_addr;
        end
        bad++;
      end
      if (fifo_ready !== 1'b0 || rd_en !== 1'b0 || clear_done !== 1'b0) side++;
      busy    = ($urandom_range(0, 7) == 0);
      fb_busy = busy;
      if (!busy) begin
        exp_addr++;
        if (exp_addr == N_PIX) begin
          done = 1'b1;
          break;
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL clear_timeout: got %0d accepts expected %0d", exp_addr, N_PIX);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL clear_seq: got %0d bad cycles, first addr %0d expected %0d", bad, first_bad_addr, first_bad_exp);
    end
    n_checks++;
    if (side != 0) begin
      n_errors++;
      $display("FAIL clear_side: got %0d cycles with ready/rd_en/done high expected 0", side);
    end
    fb_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (clear_done !== 1'b1 || fb_we !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_done: got done %b we %b expected 1 0", clear_done, fb_we);
    end
    clear_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (clear_done !== 1'b0 || fifo_ready !== 1'b1 || fb_we !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_exit: got done %b ready %b we %b expected 0 1 0", clear_done, fifo_ready, fb_we);
    end
  endtask

  task automatic test_clear_after_write();
    exp_t e;
    bit   ok;
    int   side = 0;
    bit   reached = 1'b0;
    fb_busy = 1'b0;
    push_frag(7, 3, 1, 2, 3);
    push_frag(8, 3, 4, 5, 6);
    wait_rd_en(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL cw_rd_en_timeout: got no rd_en expected rd_en");
    end
    repeat (2) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL cw_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    clear_color = 18'h2AAAA;
    clear_req   = 1'b1;
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b0 || rd_en !== 1'b0 || pixel_count !== 32'(exp_pixels)) begin
      n_errors++;
      $display("FAIL cw_write_first: got we %b rd_en %b count %0d expected 0 0 %0d",
               fb_we, rd_en, pixel_count, exp_pixels);
    end
    @(negedge clk);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd0 || fb_data !== 18'h2AAAA || fifo_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL cw_clear_start: got we %b addr %0d data %h ready %b expected 1 0 2aaaa 0",
               fb_we, fb_addr, fb_data, fifo_ready);
    end
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || fifo_ready !== 1'b0) side++;
      if (fb_addr === 19'd1000) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached) begin
      n_errors++;
      $display("FAIL cw_addr_timeout: got addr %0d expected 1000", fb_addr);
    end
    n_checks++;
    if (side != 0) begin
      n_errors++;
      $display("FAIL cw_no_pop: got %0d cycles with rd_en/ready high expected 0", side);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    #2;
    rst_n     = 1'b0;
    clear_req = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, fb_we, clear_done, fifo_ready} !== 4'b0 || fb_addr !== 19'd0 || fb_data !== 18'd0 ||
        pixel_count !== 32'd0 || drop_count !== 16'd0) begin
      n_errors++;
      $display("FAIL async_reset: got ctl %b addr %0d data %h count %0d drops %0d expected all 0",
               {rd_en, fb_we, clear_done, fifo_ready}, fb_addr, fb_data, pixel_count, drop_count);
    end
    exp_pixels = 0;
    exp_drops  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_ready !== 1'b1 || fb_we !== 1'b0 || rd_en !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: got ready %b we %b rd_en %b expected 1 0 1", fifo_ready, fb_we, rd_en);
    end
    repeat (2) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
      n_errors++;
      $display("FAIL post_reset_write: got we %b addr %0d data %h expected 1 %0d %h",
               fb_we, fb_addr, fb_data, e.addr, e.data);
    end
    exp_pixels++;
    @(negedge clk);
    n_checks++;
    if (pixel_count !== 32'(exp_pixels) || fb_we !== 1'b0 || fifo_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_count: got count %0d we %b ready %b expected %0d 0 1",
               pixel_count, fb_we, fifo_ready, exp_pixels);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    clear_req   = 1'b0;
    clear_color = 18'd0;
    fb_busy     = 1'b0;
    test_reset();
    test_drop();
    test_busy();
    test_clear();
    test_clear_after_write();
    test_reset_mid_clear();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
